// File: rtl/dual_port_ram_be.sv
`default_nettype none
// ============================================================================
// Module   : dual_port_ram_be
// Function : True dual-port RAM with byte-lane write enables, selectable
//            read-during-write mode, collision resolution and 1/2-stage reads.
// Revision : 1.0  initial release
// ============================================================================
module dual_port_ram_be #(
    parameter int    DATA_WIDTH     = 32,
    parameter int    BYTE_WIDTH     = 8,
    parameter int    DEPTH          = 64,
    parameter int    ADDR_WIDTH     = $clog2(DEPTH),
    parameter int    RD_LATENCY     = 1,
    parameter string RDW_MODE       = "WRITE_FIRST",
    parameter string COLLISION_PRIO = "A"
) (
    input  logic                             clk,
    input  logic                             async_rst_n,
    input  logic                             clk_en,
    input  logic                             en_a,
    input  logic                             en_b,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_a,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_b,
    input  logic [ADDR_WIDTH-1:0]            addr_a,
    input  logic [ADDR_WIDTH-1:0]            addr_b,
    input  logic [DATA_WIDTH-1:0]            wr_data_a,
    input  logic [DATA_WIDTH-1:0]            wr_data_b,
    output logic [DATA_WIDTH-1:0]            rd_data_a,
    output logic [DATA_WIDTH-1:0]            rd_data_b,
    output logic                             rd_valid_a,
    output logic                             rd_valid_b,
    output logic                             collision
);

    localparam int         c_NB      = DATA_WIDTH / BYTE_WIDTH;
    localparam logic       c_PRIO_B  = (COLLISION_PRIO == "B");
    localparam logic [1:0] c_RDW_WF  = 2'd0;
    localparam logic [1:0] c_RDW_RF  = 2'd1;
    localparam logic [1:0] c_RDW_NC  = 2'd2;
    localparam logic [1:0] c_RDW     = (RDW_MODE == "READ_FIRST") ? c_RDW_RF :
                                       (RDW_MODE == "NO_CHANGE")  ? c_RDW_NC : c_RDW_WF;

    generate
        if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_err_width
            $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
        end
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_err_latency
            $error("RD_LATENCY must be 1 or 2");
        end
        if (RDW_MODE != "WRITE_FIRST" && RDW_MODE != "READ_FIRST" && RDW_MODE != "NO_CHANGE") begin : g_err_rdw
            $error("RDW_MODE must be WRITE_FIRST, READ_FIRST or NO_CHANGE");
        end
        if (COLLISION_PRIO != "A" && COLLISION_PRIO != "B") begin : g_err_prio
            $error("COLLISION_PRIO must be A or B");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                       w_acc_a, w_acc_b;
    logic                       w_inr_a, w_inr_b;
    logic                       w_same, w_coll;
    logic [DATA_WIDTH-1:0]      w_old_a, w_old_b;
    logic [DATA_WIDTH-1:0]      w_fin_a, w_fin_b;
    logic [c_NB-1:0]            w_wl_a, w_wl_b;
    logic [1:0]                 w_rv;
    logic [1:0][DATA_WIDTH-1:0] w_rd;

    assign w_acc_a = clk_en & en_a;
    assign w_acc_b = clk_en & en_b;
    assign w_inr_a = (int'(addr_a) < DEPTH);
    assign w_inr_b = (int'(addr_b) < DEPTH);
    assign w_old_a = w_inr_a ? r_mem[addr_a] : '0;
    assign w_old_b = w_inr_b ? r_mem[addr_b] : '0;
    assign w_same  = w_acc_a & w_acc_b & (addr_a == addr_b);
    assign w_coll  = w_same & (|(we_a | we_b));

    // A lane shared by both writers is dropped from the losing port, so the
    // two write paths never touch the same bits and the stored word equals
    // the merged word seen by a write-first reader.
    generate
        for (genvar i = 0; i < c_NB; i++) begin : g_lane
            localparam int c_LO = i * BYTE_WIDTH;
            assign w_wl_a[i] = w_acc_a & w_inr_a & we_a[i] & ~(w_same & we_b[i] & c_PRIO_B);
            assign w_wl_b[i] = w_acc_b & w_inr_b & we_b[i] & ~(w_same & we_a[i] & ~c_PRIO_B);
            assign w_fin_a[c_LO +: BYTE_WIDTH] = w_wl_a[i]            ? wr_data_a[c_LO +: BYTE_WIDTH] :
                                                 (w_same & w_wl_b[i]) ? wr_data_b[c_LO +: BYTE_WIDTH] :
                                                                        w_old_a[c_LO +: BYTE_WIDTH];
            assign w_fin_b[c_LO +: BYTE_WIDTH] = w_wl_b[i]            ? wr_data_b[c_LO +: BYTE_WIDTH] :
                                                 (w_same & w_wl_a[i]) ? wr_data_a[c_LO +: BYTE_WIDTH] :
                                                                        w_old_b[c_LO +: BYTE_WIDTH];
        end
    endgenerate

    always_comb begin
        w_rv[0] = w_acc_a & ~((c_RDW == c_RDW_NC) & (|we_a));
        w_rv[1] = w_acc_b & ~((c_RDW == c_RDW_NC) & (|we_b));
        w_rd[0] = ((we_a == '0) || (c_RDW == c_RDW_RF)) ? w_old_a : (w_inr_a ? w_fin_a : '0);
        w_rd[1] = ((we_b == '0) || (c_RDW == c_RDW_RF)) ? w_old_b : (w_inr_b ? w_fin_b : '0);
    end

    always_ff @(posedge clk) begin
        if (async_rst_n) begin
            for (int i = 0; i < c_NB; i++) begin
                if (w_wl_a[i]) r_mem[addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
                if (w_wl_b[i]) r_mem[addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    logic [1:0]                 r_s1_v;
    logic [1:0][DATA_WIDTH-1:0] r_s1_d;
    logic                       r_s1_c;
    logic [1:0]                 w_out_v;
    logic [1:0][DATA_WIDTH-1:0] w_out_d;
    logic                       w_out_c;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_s1_v <= '0;
            r_s1_d <= '0;
            r_s1_c <= 1'b0;
        end else if (clk_en) begin
            r_s1_v <= w_rv;
            r_s1_c <= w_coll;
            for (int p = 0; p < 2; p++) begin
                if (w_rv[p]) r_s1_d[p] <= w_rd[p];
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [1:0]                 r_s2_v;
            logic [1:0][DATA_WIDTH-1:0] r_s2_d;
            logic                       r_s2_c;

            always_ff @(posedge clk or negedge async_rst_n) begin
                if (!async_rst_n) begin
                    r_s2_v <= '0;
                    r_s2_d <= '0;
                    r_s2_c <= 1'b0;
                end else if (clk_en) begin
                    r_s2_v <= r_s1_v;
                    r_s2_c <= r_s1_c;
                    for (int p = 0; p < 2; p++) begin
                        if (r_s1_v[p]) r_s2_d[p] <= r_s1_d[p];
                    end
                end
            end

            assign w_out_v = r_s2_v;
            assign w_out_d = r_s2_d;
            assign w_out_c = r_s2_c;
        end else begin : g_lat1
            assign w_out_v = r_s1_v;
            assign w_out_d = r_s1_d;
            assign w_out_c = r_s1_c;
        end
    endgenerate

    // Pulses are masked while frozen so each result is flagged in exactly one
    // enabled cycle; the held registers re-present it once clk_en returns.
    assign rd_data_a  = w_out_d[0];
    assign rd_data_b  = w_out_d[1];
    assign rd_valid_a = w_out_v[0] & clk_en;
    assign rd_valid_b = w_out_v[1] & clk_en;
    assign collision  = w_out_c & clk_en;

endmodule
`default_nettype wire
